float_compare_branch: RTL and testbench

Sequencing stage directly downstream of the floating-point comparator. It accepts a pair of IEEE-754 single-precision operands plus a condition code, drives the comparator's operand and enable inputs for one cycle, and latches the comparator's 2-bit sign result. It then resolves the condition into a branch-taken decision and a flags word for the fetch/branch logic. Requests are accepted only while idle, and the decision is presented with a one-cycle done pulse.

---
 rtl/float_compare_branch_if.sv | 18 +
 rtl/float_compare_branch.sv | 140 ++++++++++++++
 tb/tb_float_compare_branch.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/float_compare_branch_if.sv
// Request/response bundle between the branch unit and float_compare_branch.
interface float_compare_branch_if #(
  parameter int COND_W = 3
) ();
  logic              start;
  logic [31:0]       a;
  logic [31:0]       b;
  logic [COND_W-1:0] cond;
  logic              busy;
  logic              done;
  logic              taken;
  logic [2:0]        flags;

  // start is a strobe that is only accepted while busy is low; each accepted
  // start yields exactly one done pulse, and taken/flags hold after that pulse.
  modport master (output start, a, b, cond, input  busy, done, taken, flags);
  modport slave  (input  start, a, b, cond, output busy, done, taken, flags);
endinterface

// File: rtl/float_compare_branch.sv
// Sequences one float compare through the external comparator and resolves a
// branch condition. Optional NaN override: define FLOAT_NAN_CHECK_EN.
module float_compare_branch #(
  parameter int COND_W = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  float_compare_branch_if.slave bus,
  output logic [31:0]           cmpA,
  output logic [31:0]           cmpB,
  output logic                  cmpEnable,
  input  logic [1:0]            cmpOut,
  output logic [2:0]            dbg_state_o
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE   = 3'd1,
    WAIT    = 3'd2,
    RESOLVE = 3'd3,
    DONE    = 3'd4
  } state_t;

  localparam logic [COND_W-1:0] C_EQ     = COND_W'(0);
  localparam logic [COND_W-1:0] C_NE     = COND_W'(1);
  localparam logic [COND_W-1:0] C_LT     = COND_W'(2);
  localparam logic [COND_W-1:0] C_LE     = COND_W'(3);
  localparam logic [COND_W-1:0] C_GT     = COND_W'(4);
  localparam logic [COND_W-1:0] C_GE     = COND_W'(5);
  localparam logic [COND_W-1:0] C_ALWAYS = COND_W'(6);

  state_t            state_q;
  logic [31:0]       a_q, b_q;
  logic [COND_W-1:0] cond_q;
  logic [1:0]        res_q;
  logic              nan_q;
  logic              busy_q, done_q, taken_q, en_q;
  logic [2:0]        flags_q;

  logic              nan_d;
  logic              unord_d;
  logic              taken_d;
  logic [2:0]        flags_d;

`ifdef FLOAT_NAN_CHECK_EN
  function automatic logic is_nan(input logic [31:0] v);
    return (v[30:23] == 8'hFF) && (v[22:0] != 23'd0);
  endfunction
  assign nan_d = is_nan(bus.a) | is_nan(bus.b);
`else
  assign nan_d = 1'b0;
`endif

  // A NaN operand forces the unordered encoding regardless of what the
  // comparator reported.
  always_comb begin
    unord_d = nan_q | (res_q == 2'b10);
    flags_d = unord_d ? 3'b110 : {1'b0, res_q};
    taken_d = 1'b0;
    if (unord_d) begin
      taken_d = (cond_q == C_NE) || (cond_q == C_ALWAYS);
    end else begin
      case (cond_q)
        C_EQ:     taken_d = (res_q == 2'b00);
        C_NE:     taken_d = (res_q != 2'b00);
        C_LT:     taken_d = (res_q == 2'b11);
        C_LE:     taken_d = (res_q == 2'b11) || (res_q == 2'b00);
        C_GT:     taken_d = (res_q == 2'b01);
        C_GE:     taken_d = (res_q == 2'b01) || (res_q == 2'b00);
        C_ALWAYS: taken_d = 1'b1;
        default:  taken_d = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      cond_q  <= '0;
      res_q   <= '0;
      nan_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      taken_q <= 1'b0;
      en_q    <= 1'b0;
      flags_q <= '0;
    end else begin
      done_q <= 1'b0;
      en_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            a_q     <= bus.a;
            b_q     <= bus.b;
            cond_q  <= bus.cond;
            nan_q   <= nan_d;
            en_q    <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          state_q <= WAIT;
        end
        WAIT: begin
          res_q   <= cmpOut;
          state_q <= RESOLVE;
        end
        RESOLVE: begin
          taken_q <= taken_d;
          flags_q <= flags_d;
          done_q  <= 1'b1;
          state_q <= DONE;
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Holding registers feed the comparator directly so its inputs stay stable
  // from ISSUE until the next capture.
  assign cmpA        = a_q;
  assign cmpB        = b_q;
  assign cmpEnable   = en_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.taken   = taken_q;
  assign bus.flags   = flags_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_float_compare_branch.sv
// Bench for float_compare_branch: directed plan cases plus randomized requests
// scored against a value-level float ordering model.
module tb_float_compare_branch;

  localparam logic [2:0] EQ = 3'd0, NE = 3'd1, LT = 3'd2, LE = 3'd3;
  localparam logic [2:0] GT = 3'd4, GE = 3'd5, ALWAYS = 3'd6, NEVER = 3'd7;

  logic        clk;
  logic        reset;
  logic [31:0] cmp_a, cmp_b;
  logic        cmp_en;
  logic [1:0]  cmp_out;
  logic [2:0]  dbg_state;

  int checks = 0;
  int errors = 0;
  logic [3:0] exp_q[$];

  float_compare_branch_if #(.COND_W(3)) bus ();

  float_compare_branch #(.COND_W(3)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .cmpA       (cmp_a),
    .cmpB       (cmp_b),
    .cmpEnable  (cmp_en),
    .cmpOut     (cmp_out),
    .dbg_state_o(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic bit is_nan(input logic [31:0] v);
    return (v[30:23] == 8'hFF) && (v[22:0] != 23'd0);
  endfunction

  // Sign-magnitude float bits map monotonically onto signed integers.
  function automatic longint ord_val(input logic [31:0] v);
    longint m;
    m = longint'({33'd0, v[30:0]});
    return v[31] ? -m : m;
  endfunction

  // -1: x<y, 0: equal, 1: x>y, 2: unordered
  function automatic int rel(input logic [31:0] x, input logic [31:0] y);
    if (is_nan(x) || is_nan(y)) return 2;
    if (ord_val(x) < ord_val(y)) return -1;
    if (ord_val(x) > ord_val(y)) return 1;
    return 0;
  endfunction

  // Bench-side comparator: unordered inputs yield the 10 code.
  always_comb begin
    cmp_out = 2'b10;
    case (rel(cmp_a, cmp_b))
      -1:      cmp_out = 2'b11;
      0:       cmp_out = 2'b00;
      1:       cmp_out = 2'b01;
      default: cmp_out = 2'b10;
    endcase
  end

  function automatic logic [3:0] expect_of(input logic [31:0] x, input logic [31:0] y,
                                           input logic [2:0] c);
    int  r;
    bit  t;
    logic [2:0] f;
    r = rel(x, y);
    if (r == 2) begin
      f = 3'b110;
      t = (c == NE) || (c == ALWAYS);
    end else begin
      f = (r == 0) ? 3'b000 : (r > 0) ? 3'b001 : 3'b011;
      case (c)
        EQ:      t = (r == 0);
        NE:      t = (r != 0);
        LT:      t = (r < 0);
        LE:      t = (r <= 0);
        GT:      t = (r > 0);
        GE:      t = (r >= 0);
        ALWAYS:  t = 1'b1;
        default: t = 1'b0;
      endcase
    end
    return {t, f};
  endfunction

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},  64'(bus.busy),  64'd0);
    check({tag, "_done"},  64'(bus.done),  64'd0);
    check({tag, "_taken"}, 64'(bus.taken), 64'd0);
    check({tag, "_flags"}, 64'(bus.flags), 64'd0);
    check({tag, "_en"},    64'(cmp_en),    64'd0);
    check({tag, "_cmpa"},  64'(cmp_a),     64'd0);
    check({tag, "_cmpb"},  64'(cmp_b),     64'd0);
    check({tag, "_state"}, 64'(dbg_state), 64'd0);
  endtask

  // ---------------- driver ----------------
  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (bus.busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_idle_timeout"}, 64'(bus.busy), 64'd0);
  endtask

  task automatic run_req(input string tag, input logic [31:0] av, input logic [31:0] bv,
                         input logic [2:0] cv, input bit repulse);
    int done_cnt, done_cyc, en_cnt;
    logic [3:0] expv, got;
    wait_idle(tag);
    expv = expect_of(av, bv, cv);
    exp_q.push_back(expv);
    got = '0;
    done_cnt = 0;
    done_cyc = 0;
    en_cnt = 0;
    @(negedge clk);
    bus.a = av;
    bus.b = bv;
    bus.cond = cv;
    bus.start = 1'b1;
    for (int cyc = 1; cyc <= 6; cyc++) begin
      @(negedge clk);
      bus.start = repulse && (cyc <= 3);
      if (repulse) begin
        bus.a = $urandom;
        bus.b = $urandom;
        bus.cond = 3'($urandom_range(0, 7));
      end
      if (cmp_en) en_cnt++;
      if (cyc == 1) check({tag, "_busy_c1"}, 64'(bus.busy), 64'd1);
      if (cyc == 2) check({tag, "_operands_c2"}, {cmp_a, cmp_b}, {av, bv});
      if (cyc == 5) check({tag, "_busy_c5"}, 64'(bus.busy), 64'd0);
      if (bus.done) begin
        done_cnt++;
        done_cyc = cyc;
        got = {bus.taken, bus.flags};
        if (exp_q.size() != 0) check({tag, "_result"}, 64'(got), 64'(exp_q.pop_front()));
      end
      if (cyc == 6) check({tag, "_held"}, 64'({bus.taken, bus.flags}), 64'(expv));
    end
    check({tag, "_done_count"}, 64'(done_cnt), 64'd1);
    check({tag, "_done_cycle"}, 64'(done_cyc), 64'd4);
    check({tag, "_en_pulses"}, 64'(en_cnt), 64'd1);
    check({tag, "_sb_empty"}, 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int done_seen;
    logic [31:0] ra, rb;
    bus.start = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.cond = '0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0;
    @(negedge clk);

    run_req("lt_1_2",   32'h3F800000, 32'h40000000, LT, 1'b0);
    check("lt_1_2_flags", 64'(bus.flags), 64'b011);
    run_req("eq_3_3",   32'h40400000, 32'h40400000, EQ, 1'b0);
    run_req("ne_3_3",   32'h40400000, 32'h40400000, NE, 1'b0);
    run_req("ge_repulse", 32'h40000000, 32'hBF800000, GE, 1'b1);
    run_req("never_eq", 32'h40400000, 32'h40400000, NEVER, 1'b0);
    run_req("nan_lt",   32'h7FC00000, 32'h3F800000, LT, 1'b0);
    run_req("nan_ne",   32'h7FC00000, 32'h3F800000, NE, 1'b0);
    run_req("gt_neg",   32'hC0000000, 32'hBF800000, GT, 1'b0);
    run_req("le_inf",   32'h3F800000, 32'h7F800000, LE, 1'b0);
    run_req("always_nan", 32'h3F800000, 32'h7F800001, ALWAYS, 1'b0);

    // Reset during WAIT aborts the request without a done pulse.
    wait_idle("abort");
    @(negedge clk);
    bus.a = 32'h3F800000;
    bus.b = 32'h3F800000;
    bus.cond = EQ;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    check("abort_in_wait", 64'(dbg_state), 64'd2);
    reset = 1'b1;
    #1;
    check_all_zero("abort");
    @(negedge clk);
    reset = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.done) done_seen++;
    end
    check("abort_no_done", 64'(done_seen), 64'd0);
    run_req("after_abort", 32'h40000000, 32'h3F800000, GT, 1'b0);

    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      case ($urandom_range(0, 4))
        0:       rb = ra;
        1:       rb = {~ra[31], ra[30:0]};
        2:       rb = {ra[31], 8'hFF, 23'($urandom_range(1, 8388607))};
        default: rb = $urandom;
      endcase
      run_req($sformatf("rand%0d", i), ra, rb, 3'($urandom_range(0, 7)),
              bit'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
